// File: rtl/c2f_burst_writer.sv
// Turns parsed CPU->FPGA write requests (header + qword beats) into byte-masked C2F chunk RAM
// writes, and owns the doorbell-driven wrIndex published to the consumer.
module c2f_burst_writer #(
  parameter int unsigned OFS_NBITS = 9,
  parameter int unsigned IDX_NBITS = 3,
  parameter int unsigned LEN_NBITS = 10
) (
  input  logic                           sysClk,
  input  logic                           sysRst_n,
  input  logic                           hdrValid,
  output logic                           hdrReady,
  input  logic [IDX_NBITS+OFS_NBITS-1:0] hdrAddr,
  input  logic [LEN_NBITS-1:0]           hdrLen,
  input  logic [7:0]                     hdrFirstBE,
  input  logic [7:0]                     hdrLastBE,
  input  logic                           datValid,
  output logic                           datReady,
  input  logic [63:0]                    datData,
  input  logic                           dbValid,
  input  logic [IDX_NBITS-1:0]           dbIndex,
  input  logic [IDX_NBITS-1:0]           rdIndex,
  output logic                           ramWrEnable,
  output logic [7:0]                     ramWrByteMask,
  output logic [IDX_NBITS+OFS_NBITS-1:0] ramWrAddr,
  output logic [63:0]                    ramWrData,
  output logic [IDX_NBITS-1:0]           wrIndex,
  output logic [IDX_NBITS-1:0]           freeChunks,
  output logic [1:0]                     errSticky
);

  localparam int unsigned AddrW = IDX_NBITS + OFS_NBITS;
  localparam logic [31:0] WindowQwords = 32'(1) << AddrW;
  localparam logic [IDX_NBITS-1:0] IdxMax = '1;

  typedef enum logic [1:0] {StIdle, StData, StDrop} state_e;

  state_e               state_q, state_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [LEN_NBITS-1:0] remain_q, remain_d;
  logic                 first_q, first_d;
  logic [7:0]           first_be_q, first_be_d;
  logic [7:0]           last_be_q, last_be_d;
  logic                 hdr_rdy_q, hdr_rdy_d;
  logic                 dat_rdy_q, dat_rdy_d;

  logic                 ram_en_q;
  logic [7:0]           ram_mask_q, ram_mask_d;
  logic [AddrW-1:0]     ram_addr_q;
  logic [63:0]          ram_data_q;

  logic [IDX_NBITS-1:0] wr_idx_q, wr_idx_d;
  logic                 db_pend_q, db_pend_d;
  logic [IDX_NBITS-1:0] db_pend_idx_q, db_pend_idx_d;
  logic [1:0]           err_q;

  logic                 hdr_fire, dat_fire, hdr_bad, beat_last, data_write;
  logic                 err_drop, err_ovf, db_go;
  logic [IDX_NBITS-1:0] db_val;
  logic [31:0]          end_addr;

  assign hdr_fire   = hdrValid & hdr_rdy_q;
  assign dat_fire   = datValid & dat_rdy_q;
  assign end_addr   = 32'(hdrAddr) + 32'(hdrLen);
  assign hdr_bad    = (hdrLen == '0) || (end_addr > WindowQwords);
  assign beat_last  = (remain_q == LEN_NBITS'(1));
  assign data_write = dat_fire && (state_q == StData);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    first_d    = first_q;
    first_be_d = first_be_q;
    last_be_d  = last_be_q;
    err_drop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hdr_fire) begin
          addr_d     = hdrAddr;
          remain_d   = hdrLen;
          first_d    = 1'b1;
          first_be_d = hdrFirstBE;
          last_be_d  = hdrLastBE;
          if (hdr_bad) begin
            state_d  = StDrop;
            err_drop = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (dat_fire) begin
          addr_d   = addr_q + AddrW'(1);
          remain_d = remain_q - LEN_NBITS'(1);
          first_d  = 1'b0;
          if (beat_last) state_d = StIdle;
        end
      end
      StDrop: begin
        // A zero-length drop has nothing to swallow and leaves straight away.
        if (remain_q == '0) begin
          state_d = StIdle;
        end else if (dat_fire) begin
          remain_d = remain_q - LEN_NBITS'(1);
          if (beat_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    hdr_rdy_d = (state_d == StIdle);
    dat_rdy_d = (state_d == StData) || ((state_d == StDrop) && (remain_d != '0));
  end

  always_comb begin
    ram_mask_d = 8'hFF;
    if (first_q && beat_last) begin
      ram_mask_d = first_be_q & last_be_q;
    end else if (first_q) begin
      ram_mask_d = first_be_q;
    end else if (beat_last) begin
      ram_mask_d = last_be_q;
    end
  end

  // Doorbells seen mid-burst are parked and only published once the FSM is back in idle,
  // so the consumer never sees a chunk whose final write is still in flight.
  always_comb begin
    wr_idx_d      = wr_idx_q;
    db_pend_d     = db_pend_q;
    db_pend_idx_d = db_pend_idx_q;
    err_ovf       = 1'b0;
    db_go         = 1'b0;
    db_val        = db_pend_idx_q;
    if (state_q == StIdle) begin
      db_go     = dbValid | db_pend_q;
      db_val    = dbValid ? dbIndex : db_pend_idx_q;
      db_pend_d = 1'b0;
      if (db_go) begin
        if ((db_val == rdIndex) && (db_val != wr_idx_q)) begin
          err_ovf = 1'b1;
        end else begin
          wr_idx_d = db_val;
        end
      end
    end else if (dbValid) begin
      db_pend_d     = 1'b1;
      db_pend_idx_d = dbIndex;
    end
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remain_q      <= '0;
      first_q       <= 1'b0;
      first_be_q    <= '0;
      last_be_q     <= '0;
      hdr_rdy_q     <= 1'b0;
      dat_rdy_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_mask_q    <= '0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      wr_idx_q      <= '0;
      db_pend_q     <= 1'b0;
      db_pend_idx_q <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      first_q       <= first_d;
      first_be_q    <= first_be_d;
      last_be_q     <= last_be_d;
      hdr_rdy_q     <= hdr_rdy_d;
      dat_rdy_q     <= dat_rdy_d;
      ram_en_q      <= data_write;
      if (data_write) begin
        ram_mask_q <= ram_mask_d;
        ram_addr_q <= addr_q;
        ram_data_q <= datData;
      end
      wr_idx_q      <= wr_idx_d;
      db_pend_q     <= db_pend_d;
      db_pend_idx_q <= db_pend_idx_d;
      err_q         <= err_q | {err_ovf, err_drop};
    end
  end

  assign hdrReady      = hdr_rdy_q;
  assign datReady      = dat_rdy_q;
  assign ramWrEnable   = ram_en_q;
  assign ramWrByteMask = ram_mask_q;
  assign ramWrAddr     = ram_addr_q;
  assign ramWrData     = ram_data_q;
  assign wrIndex       = wr_idx_q;
  assign freeChunks    = IdxMax - (wr_idx_q - rdIndex);
  assign errSticky     = err_q;

endmodule

// File: tb/tb_c2f_burst_writer.sv
// Randomized self-checking bench for c2f_burst_writer: expected RAM writes are queued per request
// from the masking/window rules, and wrIndex/freeChunks/errSticky come from a doorbell model.
module tb_c2f_burst_writer;

  localparam int unsigned IDX = 3;
  localparam int unsigned LEN = 10;
  localparam int unsigned AW  = 12;

  logic          sysClk = 1'b0;
  logic          sysRst_n = 1'b0;
  logic          hdrValid = 1'b0, hdrReady;
  logic [AW-1:0] hdrAddr = '0;
  logic [LEN-1:0] hdrLen = '0;
  logic [7:0]    hdrFirstBE = '0, hdrLastBE = '0;
  logic          datValid = 1'b0, datReady;
  logic [63:0]   datData = '0;
  logic          dbValid = 1'b0;
  logic [IDX-1:0] dbIndex = '0, rdIndex = '0;
  logic          ramWrEnable;
  logic [7:0]    ramWrByteMask;
  logic [AW-1:0] ramWrAddr;
  logic [63:0]   ramWrData;
  logic [IDX-1:0] wrIndex, freeChunks;
  logic [1:0]    errSticky;

  always #5 sysClk = ~sysClk;

  c2f_burst_writer #(.OFS_NBITS(9), .IDX_NBITS(IDX), .LEN_NBITS(LEN)) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n),
    .hdrValid(hdrValid), .hdrReady(hdrReady), .hdrAddr(hdrAddr), .hdrLen(hdrLen),
    .hdrFirstBE(hdrFirstBE), .hdrLastBE(hdrLastBE),
    .datValid(datValid), .datReady(datReady), .datData(datData),
    .dbValid(dbValid), .dbIndex(dbIndex), .rdIndex(rdIndex),
    .ramWrEnable(ramWrEnable), .ramWrByteMask(ramWrByteMask), .ramWrAddr(ramWrAddr),
    .ramWrData(ramWrData), .wrIndex(wrIndex), .freeChunks(freeChunks), .errSticky(errSticky)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    mask;
    logic [63:0]   data;
  } wr_t;

  wr_t            exp_q[$];
  wr_t            mon_e;
  bit             mon_en = 1'b1;
  logic [IDX-1:0] m_wr = '0;
  logic [1:0]     m_err = '0;

  always @(negedge sysClk) begin
    if (mon_en && sysRst_n && ramWrEnable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(ramWrAddr), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(ramWrAddr), 64'(mon_e.addr));
        check("wr_mask", 64'(ramWrByteMask), 64'(mon_e.mask));
        check("wr_data", ramWrData, mon_e.data);
      end
    end
  end

  function automatic logic [7:0] be_of(int i, int len, logic [7:0] f, logic [7:0] l);
    if (len == 1) return f & l;
    if (i == 0) return f;
    if (i == len - 1) return l;
    return 8'hFF;
  endfunction

  task automatic send_req(input logic [AW-1:0] addr, input logic [LEN-1:0] len,
                          input logic [7:0] fbe, input logic [7:0] lbe,
                          input int unsigned gap_pct, input bit seq);
    logic [63:0] pay[$];
    wr_t w;
    bit bad;
    int unsigned to;
    bad = (len == 0) || (int'(addr) + int'(len) > 4096);
    for (int i = 0; i < int'(len); i++) pay.push_back(seq ? 64'(i) : {$urandom, $urandom});
    if (!bad) begin
      for (int i = 0; i < int'(len); i++) begin
        w.addr = AW'(int'(addr) + i);
        w.mask = be_of(i, int'(len), fbe, lbe);
        w.data = pay[i];
        exp_q.push_back(w);
      end
    end else begin
      m_err[0] = 1'b1;
    end
    hdrAddr = addr; hdrLen = len; hdrFirstBE = fbe; hdrLastBE = lbe; hdrValid = 1'b1;
    to = 0;
    while (!hdrReady && to < 200) begin
      @(negedge sysClk);
      to++;
    end
    if (!hdrReady) check("hdr_timeout", 64'd0, 64'd1);
    @(negedge sysClk);
    hdrValid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) @(negedge sysClk);
      datValid = 1'b1;
      datData = pay[i];
      to = 0;
      while (!datReady && to < 200) begin
        @(negedge sysClk);
        to++;
      end
      if (!datReady) begin
        check("dat_timeout", 64'd0, 64'd1);
        datValid = 1'b0;
        break;
      end
      @(negedge sysClk);
      datValid = 1'b0;
    end
    to = 0;
    while (exp_q.size() != 0 && to < 50) begin
      @(negedge sysClk);
      to++;
    end
    @(negedge sysClk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Doorbell while idle: takes effect on the following cycle.
  task automatic ring(input logic [IDX-1:0] idx);
    dbIndex = idx;
    dbValid = 1'b1;
    @(negedge sysClk);
    dbValid = 1'b0;
    if (idx == rdIndex && idx != m_wr) m_err[1] = 1'b1;
    else m_wr = idx;
    check("db_wr_index", 64'(wrIndex), 64'(m_wr));
  endtask

  task automatic check_status(input string tag);
    logic [IDX-1:0] used;
    used = m_wr - rdIndex;
    check({tag, "_wr_index"}, 64'(wrIndex), 64'(m_wr));
    check({tag, "_free"}, 64'(freeChunks), 64'(7 - int'(used)));
    check({tag, "_err"}, 64'(errSticky), 64'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt, to;
    repeat (3) @(negedge sysClk);
    check("rst_hdr_ready", 64'(hdrReady), 64'd0);
    check("rst_dat_ready", 64'(datReady), 64'd0);
    check("rst_ram_en", 64'(ramWrEnable), 64'd0);
    check("rst_ram_mask", 64'(ramWrByteMask), 64'd0);
    check("rst_ram_addr", 64'(ramWrAddr), 64'd0);
    check("rst_ram_data", ramWrData, 64'd0);
    check_status("rst");
    sysRst_n = 1'b1;
    @(negedge sysClk);

    // Full chunk 0 with sequential data.
    send_req(12'd0, 10'd512, 8'hFF, 8'hFF, 0, 1'b1);
    check_status("t1");

    ring(3'd1);
    check_status("t2_db");
    rdIndex = 3'd1;
    @(negedge sysClk);
    check_status("t2_ack");

    send_req(12'd600, 10'd1, 8'h0F, 8'h3C, 0, 1'b0);
    send_req(12'd700, 10'd3, 8'hF0, 8'h0F, 30, 1'b0);
    check_status("t3");

    send_req(12'd4095, 10'd2, 8'hFF, 8'hFF, 0, 1'b0);
    check_status("t4_drop");
    send_req(12'd100, 10'd4, 8'h81, 8'h7E, 20, 1'b0);
    check_status("t4_next");

    // Two doorbells mid-burst: the second wins, published one cycle after the last write.
    fork
      send_req(12'd1024, 10'd8, 8'hFF, 8'hFF, 40, 1'b0);
      begin
        to = 0;
        while (!datReady && to < 100) begin
          @(negedge sysClk);
          to++;
        end
        dbIndex = 3'd2; dbValid = 1'b1;
        @(negedge sysClk);
        dbValid = 1'b0;
        @(negedge sysClk);
        dbIndex = 3'd3; dbValid = 1'b1;
        @(negedge sysClk);
        dbValid = 1'b0;
      end
      begin
        cnt = 0;
        to = 0;
        while (cnt < 8 && to < 200) begin
          @(negedge sysClk);
          if (ramWrEnable) cnt++;
          if (cnt < 8) check("t5_pending", 64'(wrIndex), 64'd1);
          to++;
        end
        check("t5_writes", 64'(cnt), 64'd8);
        check("t5_hold", 64'(wrIndex), 64'd1);
        @(negedge sysClk);
        check("t5_apply", 64'(wrIndex), 64'd3);
      end
    join
    m_wr = 3'd3;
    check_status("t5");

    rdIndex = 3'd2;
    ring(3'd1);
    ring(3'd2);
    check_status("t6_ovf");
    ring(3'd1);

    // One short burst per chunk, publishing each, around the ring and through 7->0.
    for (int k = 0; k < 8; k++) begin
      rdIndex = m_wr;
      send_req({m_wr, 9'd0}, 10'd4, 8'hFF, 8'hFF, 10, 1'b0);
      ring(m_wr + 3'd1);
      check_status("t6_ring");
    end

    for (int r = 0; r < 30; r++) begin
      logic [AW-1:0] a;
      logic [LEN-1:0] l;
      rdIndex = IDX'($urandom_range(7));
      a = ($urandom_range(3) == 0) ? AW'(4096 - $urandom_range(1, 8)) : AW'($urandom_range(4095));
      l = ($urandom_range(9) == 0) ? 10'd0 : LEN'($urandom_range(1, 12));
      send_req(a, l, 8'($urandom), 8'($urandom), 30, 1'b0);
      if ($urandom_range(1) == 1) ring(IDX'($urandom_range(7)));
      check_status("rand");
    end

    // Reset in the middle of a burst with a parked doorbell: nothing more is written or published.
    mon_en = 1'b0;
    hdrAddr = 12'd300; hdrLen = 10'd8; hdrFirstBE = 8'hFF; hdrLastBE = 8'hFF; hdrValid = 1'b1;
    to = 0;
    while (!hdrReady && to < 50) begin
      @(negedge sysClk);
      to++;
    end
    @(negedge sysClk);
    hdrValid = 1'b0;
    datValid = 1'b1;
    datData = 64'hDEAD_BEEF;
    dbIndex = m_wr + 3'd2;
    dbValid = 1'b1;
    @(negedge sysClk);
    dbValid = 1'b0;
    repeat (2) @(negedge sysClk);
    sysRst_n = 1'b0;
    #1;
    check("abort_ram_en", 64'(ramWrEnable), 64'd0);
    repeat (2) @(negedge sysClk);
    sysRst_n = 1'b1;
    m_wr = '0;
    m_err = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysClk);
      check("abort_no_write", 64'(ramWrEnable), 64'd0);
    end
    datValid = 1'b0;
    check_status("abort");
    check("abort_hdr_ready", 64'(hdrReady), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
